// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: FSM state encoding,
// default bit period and counter width helper.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam int unsigned DefaultBaudDiv = 16;

  // A counter must be at least one bit wide even for tiny ranges
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_cnt.sv
// Clearable bit-period counter; terminal count is half or full BaudDiv.
// The tick is registered and lines up with the cycle before the period ends.
module baud_cnt
  import serial_pkg::*;
#(
  parameter int unsigned BaudDiv = DefaultBaudDiv
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int unsigned CW = cnt_width(BaudDiv);
  localparam logic [CW-1:0] FullLast = CW'(BaudDiv - 1);
  localparam logic [CW-1:0] FullPre  = CW'(BaudDiv - 2);
  localparam logic [CW-1:0] HalfLast = CW'(BaudDiv / 2 - 1);
  localparam logic [CW-1:0] HalfPre  = CW'(BaudDiv / 2 - 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [CW-1:0] pre;

  assign last = half ? HalfLast : FullLast;
  assign pre  = half ? HalfPre  : FullPre;

  // Tick is raised one count early so the FSM acts exactly on the period edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == last) ? '0 : cnt + CW'(1);
      tick <= (cnt == pre);
    end
  end

endmodule

// File: rtl/serial_rx_ctrl.sv
// Serial receive controller feeding a MSB-first shift register.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit check before stop.
module serial_rx_ctrl
  import serial_pkg::*;
#(
  parameter int unsigned Width   = 8,
  parameter int unsigned BaudDiv = DefaultBaudDiv
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic d_o,
  output logic en_o,
  output logic done_o,
  output logic err_o,
  output logic busy_o
);

  localparam int unsigned BW = $clog2(Width + 1);
  localparam logic [BW-1:0] LastBit = BW'(Width - 1);

  state_e        state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic          rx_meta, rx_s;
  logic          par_acc, par_acc_nxt;
  logic          par_err, par_err_nxt;
  logic          d_nxt, en_nxt, done_nxt, err_nxt;
  logic          cnt_clear, cnt_half, tick;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  baud_cnt #(.BaudDiv(BaudDiv)) u_baud_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (cnt_clear),
    .half   (cnt_half),
    .tick   (tick)
  );

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    par_acc_nxt = par_acc;
    par_err_nxt = par_err;
    d_nxt       = d_o;
    en_nxt      = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    cnt_clear   = 1'b0;
    cnt_half    = (state == ST_START);
    case (state)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (tick) begin
          cnt_clear = 1'b1;
          if (!rx_s) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
            par_acc_nxt = 1'b0;
            par_err_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          d_nxt       = rx_s;
          en_nxt      = 1'b1;
          par_acc_nxt = par_acc ^ rx_s;
          bit_cnt_nxt = bit_cnt + BW'(1);
          if (bit_cnt == LastBit) begin
`ifdef SERIAL_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          par_err_nxt = par_acc ^ rx_s;
          state_nxt   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_nxt = ST_IDLE;
          if (rx_s && !par_err) done_nxt = 1'b1;
          else                  err_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so busy drops with done/err
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      par_acc <= 1'b0;
      par_err <= 1'b0;
      d_o     <= 1'b0;
      en_o    <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_acc <= par_acc_nxt;
      par_err <= par_err_nxt;
      d_o     <= d_nxt;
      en_o    <= en_nxt;
      done_o  <= done_nxt;
      err_o   <= err_nxt;
      busy_o  <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Self-checking bench for serial_rx_ctrl: frame table plus reset, glitch and
// mid-frame reset sequences, with a cycle-exact event scoreboard.
module tb_serial_rx_ctrl;

  localparam int W = 8;
  localparam int B = 16;
  localparam int H = B / 2;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic rx_i = 1'b1;
  logic d_o, en_o, done_o, err_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef enum int {EV_EN = 0, EV_DONE = 1, EV_ERR = 2} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic        bitv;
    int          cyc;
    logic [W-1:0] word;
  } exp_t;
  typedef struct {
    logic [W-1:0] data;
    logic         stop;
    logic         par;
    logic         exp_done;
  } vec_t;

  exp_t         exp_q[$];
  vec_t         vecs[$];
  exp_t         mon_e;
  int           mon_kind;
  logic [W-1:0] sr = '0;

  serial_rx_ctrl #(.Width(W), .BaudDiv(B)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rx_i   (rx_i),
    .d_o    (d_o),
    .en_o   (en_o),
    .done_o (done_o),
    .err_o  (err_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Every observed strobe/pulse is matched in order against the scoreboard
  always @(negedge clk_i) begin
    if (rst_ni && (en_o || done_o || err_o)) begin
      if (en_o && !done_o && !err_o)      mon_kind = EV_EN;
      else if (done_o && !en_o && !err_o) mon_kind = EV_DONE;
      else if (err_o && !en_o && !done_o) mon_kind = EV_ERR;
      else                                mon_kind = -1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got en=%0b done=%0b err=%0b at cycle %0d, want none",
                 en_o, done_o, err_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("event_kind", mon_kind, mon_e.kind);
        check_output("event_cycle", cyc, mon_e.cyc);
        if (mon_e.kind == EV_EN) begin
          check_output("d_o", d_o, mon_e.bitv);
          check_output("busy_during_data", busy_o, 1);
          sr = {sr[W-2:0], d_o};
        end else begin
          check_output("busy_at_end", busy_o, 0);
          if (mon_e.kind == EV_DONE) check_output("assembled_word", sr, mon_e.word);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (B) @(posedge clk_i);
    #1;
  endtask

  task automatic push_en(input int s, input logic [W-1:0] data, input int k);
    exp_t e;
    e.kind = EV_EN;
    e.bitv = data[W-1-k];
    e.cyc  = s + 3 + H + B * (k + 1);
    e.word = data;
    exp_q.push_back(e);
  endtask

  // Sends one frame starting at posedge+1 and queues its expected events
  task automatic apply_stimulus(input logic [W-1:0] data, input logic stop,
                                input logic par, input logic exp_done);
    int   s;
    exp_t e;
    s = cyc;
    for (int k = 0; k < W; k++) push_en(s, data, k);
    e.kind = exp_done ? EV_DONE : EV_ERR;
    e.bitv = 1'b0;
    e.cyc  = s + 3 + H + B * (W + 1 + PB);
    e.word = data;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int k = 0; k < W; k++) drive_bit(data[W-1-k]);
    if (PB != 0) drive_bit(par);
    drive_bit(stop);
    rx_i = 1'b1;
    repeat (2 * B) @(posedge clk_i);
    #1;
  endtask

  task automatic add_vec(input logic [W-1:0] data, input logic stop, input logic par, input logic exp_done);
    vec_t v;
    v.data = data; v.stop = stop; v.par = par; v.exp_done = exp_done;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
`ifdef SERIAL_RX_PARITY_EN
    add_vec(8'hA5, 1'b1, 1'b0, 1'b1);
    add_vec(8'h0F, 1'b1, 1'b0, 1'b1);
    add_vec(8'h0F, 1'b1, 1'b1, 1'b0);
    add_vec(8'h3C, 1'b0, 1'b0, 1'b0);
    add_vec(8'h81, 1'b1, 1'b0, 1'b1);
`else
    add_vec(8'hA5, 1'b1, 1'b0, 1'b1);
    add_vec(8'h3C, 1'b0, 1'b0, 1'b0);
    add_vec(8'h81, 1'b1, 1'b0, 1'b1);
    add_vec(8'h00, 1'b1, 1'b0, 1'b1);
    add_vec(8'h6B, 1'b1, 1'b0, 1'b1);
`endif

    rst_ni = 1'b0;
    rx_i   = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 10; i++) begin
      rx_i = i[0];
      @(negedge clk_i);
      check_output("reset_outputs", {d_o, en_o, done_o, err_o, busy_o}, 5'b0);
      @(posedge clk_i); #1;
    end
    rx_i   = 1'b1;
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;

    foreach (vecs[i]) apply_stimulus(vecs[i].data, vecs[i].stop, vecs[i].par, vecs[i].exp_done);

    // Short low pulse must be rejected in START without any pulse
    rx_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    check_output("glitch_busy_high", busy_o, 1);
    repeat (2 * B) @(posedge clk_i);
    #1;
    check_output("glitch_busy_low", busy_o, 0);

    // Reset right after the third strobe of a frame
    s = cyc;
    for (int k = 0; k < 3; k++) push_en(s, 8'hE0, k);
    fork
      begin
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
      end
      begin
        repeat (3 + H + 3 * B) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check_output("midframe_reset_outputs", {d_o, en_o, done_o, err_o, busy_o}, 5'b0);
        repeat (8) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
      end
    join
    rx_i = 1'b1;
    repeat (2 * B) @(posedge clk_i);
    #1;
    apply_stimulus(8'hFF, 1'b1, 1'b0, 1'b1);

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_ctrl.md
# serial_rx_ctrl

Serial-line receive controller that sits directly upstream of the team's serial-in/parallel-out shift register. It synchronises an asynchronous serial input, detects and validates frames, and drives the shift register with one sampled bit and a single-cycle shift strobe per data bit. It flags frame completion or error so downstream logic knows when the assembled parallel word is valid.

## Interface
- `Width`, 8, data bits per frame; must be ≥ 2; must match the downstream shift register width.
- `BaudDiv`, 16, clock cycles per serial bit; must be even and ≥ 4.
- `clk_i`  input  1  system clock; all logic on the rising edge.
- `rst_ni`  input  1  reset; one clock; reset is asynchronous and active-low.
- `rx_i`  input  1  asynchronous serial line; idles high.
- `d_o`  output  1  sampled data bit; connects to the shift register serial input.
- `en_o`  output  1  one-cycle shift strobe; connects to the shift register enable.
- `done_o`  output  1  one-cycle pulse when a frame ends with a valid stop bit.
- `err_o`  output  1  one-cycle pulse on a framing or parity error.
- `busy_o`  output  1  high in every state except IDLE.

## Operation
- Line format: 1 start bit (0), `Width` data bits MSB first, optional parity bit, 1 stop bit (1).
- MSB-first order leaves the word in natural order in the left-shifting downstream register.
- `rx_i` passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value `rx_s`.
- States:
  - IDLE: when `rx_s` = 0, go to START and clear the baud counter.
  - START: count `BaudDiv/2` cycles. At terminal count:
    - if `rx_s` = 0, go to DATA, clear the baud counter and clear the bit counter;
    - otherwise go back to IDLE. This is glitch rejection: no pulse is raised.
  - DATA: at each baud terminal count (`BaudDiv` cycles):
    - register `d_o` ← `rx_s`, pulse `en_o`, increment the bit counter;
    - after bit `Width-1`, go to PARITY if it is compiled in, otherwise STOP.
  - PARITY (optional): at terminal count, sample the parity bit, then go to STOP.
  - STOP: at terminal count, sample `rx_s`:
    - `rx_s` = 1 and no parity error: pulse `done_o`;
    - otherwise: pulse `err_o`;
    - go to IDLE in either case.
- `d_o` holds its last sampled value between strobes. `en_o` never pulses outside DATA.
- Baud counter width is `$clog2(BaudDiv)`. Bit counter width is `$clog2(Width+1)`. Neither counter wraps past its terminal value.
- Reset mid-frame: outputs go to 0 immediately and the state goes to IDLE. A partially shifted word downstream is abandoned, and no `done_o` or `err_o` is raised.
- A line held low after an error: the block returns to IDLE, then START is immediately re-entered.

## Timing
- Reset values: `d_o`=0, `en_o`=0, `done_o`=0, `err_o`=0, `busy_o`=0.
- From a falling edge of `rx_i`, registered at clock 0:
  - `rx_s` falls at clock 2;
  - START is entered at clock 3.
- First `en_o` occurs `BaudDiv/2 + BaudDiv` cycles after START entry. Each later `en_o` follows the previous one by exactly `BaudDiv` cycles.
- `done_o`/`err_o` occur `BaudDiv` cycles after the last data `en_o`, or `2·BaudDiv` cycles after it with parity.
- `done_o` and `err_o` are mutually exclusive and last one cycle.
- `busy_o` falls in the same cycle as the `done_o`/`err_o` pulse.
- All outputs are registered, with no combinational path from `rx_i`.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - PARITY state present;
  - even parity over the data bits; a mismatch causes `err_o` instead of `done_o` at stop.
- Not defined: no PARITY state, and a frame is `Width+2` bits.

## Structure
- Package `serial_pkg`:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - a default `BaudDiv` constant;
  - a helper for the counter width.
- Sub-module `baud_cnt`: clearable counter with a programmable terminal count (`BaudDiv/2` or `BaudDiv`) and a registered terminal-count tick.

## Test plan
- Reset: assert `rst_ni`=0 with `rx_i` toggling → all outputs 0 and `busy_o`=0 throughout.
- Valid frame, `BaudDiv`=16, data 0xA5, parity off:
  - exactly 8 `en_o` pulses spaced 16 cycles apart;
  - `d_o` sequence 1,0,1,0,0,1,0,1;
  - `done_o` 16 cycles after the last strobe;
  - downstream register reads 0xA5.
- Glitch: `rx_i` low for 5 cycles then high → START aborts, no `en_o`, `done_o` or `err_o`, and `busy_o` falls.
- Framing error: data 0x3C with the stop bit forced to 0 → 8 strobes, then `err_o`=1 for 1 cycle, `done_o` stays 0, and the next valid frame 0x81 still gives `done_o`.
- Parity, with `SERIAL_RX_PARITY_EN`:
  - 0x0F with parity 0 → `done_o`;
  - 0x0F with parity 1 → `err_o`.
- Reset mid-frame: drop `rst_ni` after 3 strobes → outputs 0 at once; a following frame 0xFF completes with 8 strobes and `done_o`.
